// File: rtl/imem_loader.sv
// UART boot loader: receives a little-endian word count followed by that many
// 32-bit words over 8N1 serial and writes them into BRAM port A.
module imem_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] ADDR_BASE    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [3:0]  wea,
  output logic [31:0] addra,
  output logic [31:0] dia,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        frame_err
);

  localparam logic [31:0] FULL_M1 = 32'(CLKS_PER_BIT - 1);
  localparam logic [31:0] HALF_M1 = 32'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {HDR, LOAD, DONE} ld_state_t;

  rx_state_t   rx_state_q, rx_state_d;
  ld_state_t   ld_state_q, ld_state_d;
  logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        byte_valid_q, byte_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        start_ok;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d, word_full;
  logic [31:0] n_q, n_d;
  logic [31:0] idx_q, idx_d;
  logic [3:0]  wea_q, wea_d;
  logic [31:0] addra_q, addra_d;
  logic [31:0] dia_q, dia_d;
  logic        busy_q, busy_d;

  assign rx_s1_d = rx;
  assign rx_s2_d = rx_s1_q;

  // UART receiver: bits are sampled at their centre, timed from the start edge.
  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q + 32'd1;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = frame_err_q;
    start_ok     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = 32'd0;
        if (!rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = 32'd0;
          if (rx_s2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            bit_idx_d  = 3'd0;
            start_ok   = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = 32'd0;
          shift_d   = {rx_s2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d      = 32'd0;
          rx_state_d = RX_IDLE;
          if (rx_s2_q) begin
            byte_valid_d = 1'b1;
            byte_d       = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    // Once the image is loaded the serial line is ignored entirely.
    if (ld_state_q == DONE) begin
      rx_state_d   = RX_IDLE;
      cnt_d        = 32'd0;
      byte_valid_d = 1'b0;
      frame_err_d  = frame_err_q;
      start_ok     = 1'b0;
    end
  end

  assign word_full = {byte_q, word_q[31:8]};

  // Word assembly and load sequencing.
  always_comb begin
    ld_state_d = ld_state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    n_d        = n_q;
    idx_d      = idx_q;
    wea_d      = 4'h0;
    addra_d    = addra_q;
    dia_d      = dia_q;
    busy_d     = busy_q;
    if (byte_valid_q && ld_state_q != DONE) begin
      word_d     = word_full;
      byte_cnt_d = byte_cnt_q + 2'd1;
      if (byte_cnt_q == 2'd3) begin
        if (ld_state_q == HDR) begin
          n_d        = word_full;
          ld_state_d = (word_full == 32'd0) ? DONE : LOAD;
        end else begin
          wea_d   = 4'hF;
          addra_d = ADDR_BASE + {idx_q[29:0], 2'b00};
          dia_d   = word_full;
          idx_d   = idx_q + 32'd1;
        end
      end
    end
    // idx has already advanced during the write cycle, so equality marks the last word.
    if (ld_state_q == LOAD && wea_q == 4'hF && idx_q == n_q) ld_state_d = DONE;
    if (ld_state_q == HDR && start_ok) busy_d = 1'b1;
    if (ld_state_d == DONE) busy_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    byte_q  <= byte_d;
    word_q  <= word_d;
    if (rst) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_state_q   <= RX_IDLE;
      ld_state_q   <= HDR;
      cnt_q        <= 32'd0;
      bit_idx_q    <= 3'd0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      byte_cnt_q   <= 2'd0;
      n_q          <= 32'd0;
      idx_q        <= 32'd0;
      wea_q        <= 4'h0;
      addra_q      <= 32'd0;
      dia_q        <= 32'd0;
      busy_q       <= 1'b0;
    end else begin
      rx_s1_q      <= rx_s1_d;
      rx_s2_q      <= rx_s2_d;
      rx_state_q   <= rx_state_d;
      ld_state_q   <= ld_state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      byte_cnt_q   <= byte_cnt_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      wea_q        <= wea_d;
      addra_q      <= addra_d;
      dia_q        <= dia_d;
      busy_q       <= busy_d;
    end
  end

  assign wea        = wea_q;
  assign addra      = addra_q;
  assign dia        = dia_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;
  assign done       = (ld_state_q == DONE);
  assign core_rst_n = (ld_state_q == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: serial images in, BRAM writes checked against
// an expected-write queue derived from the image words.
module tb_imem_loader;
  localparam int          CPB  = 16;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [3:0]  wea;
  logic [31:0] addra, dia;
  logic        core_rst_n, busy, done, frame_err;

  imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .rx(rx), .wea(wea), .addra(addra), .dia(dia),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_addr_q[$], exp_data_q[$];
  logic [31:0] log_addr[$], log_data[$];
  bit done_next = 1'b0;
  bit mon_en    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Every write is matched against the model queue; the cycle after the last
  // expected write must show the loader finished.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (done_next) begin
        chk("done_after_last_write", {31'd0, done}, 32'd1);
        chk("core_rst_n_after_last_write", {31'd0, core_rst_n}, 32'd1);
        chk("busy_after_last_write", {31'd0, busy}, 32'd0);
        done_next = 1'b0;
      end
      if (wea !== 4'h0) begin
        log_addr.push_back(addra);
        log_data.push_back(dia);
        chk("wea_value", {28'd0, wea}, 32'hF);
        chk("done_low_during_write", {31'd0, done}, 32'd0);
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: addr %h data %h, none expected", addra, dia);
        end else begin
          chk("write_addr", addra, exp_addr_q.pop_front());
          chk("write_data", dia, exp_data_q.pop_front());
          if (exp_addr_q.size() == 0) done_next = 1'b1;
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    log_addr.delete();
    log_data.delete();
    done_next = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
    rx = stop;
    wait_cycles(CPB);
    rx = 1'b1;
    wait_cycles(CPB);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic model_writes(input logic [31:0] w[$]);
    for (int k = 0; k < w.size(); k++) begin
      exp_addr_q.push_back(BASE + 32'(4 * k));
      exp_data_q.push_back(w[k]);
    end
  endtask

  task automatic wait_done(input string name, input int maxc);
    int c = 0;
    while (done !== 1'b1 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [31:0] img[$];
    int busy_seen;

    // Reset values
    rst = 1'b1;
    rx  = 1'b1;
    wait_cycles(3);
    @(negedge clk);
    chk("rst_wea", {28'd0, wea}, 32'd0);
    chk("rst_addra", addra, 32'd0);
    chk("rst_dia", dia, 32'd0);
    chk("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    mon_en = 1'b1;

    // Two-word image
    do_reset();
    img.delete();
    img.push_back(32'h0000_0013);
    img.push_back(32'hDEAD_BEEF);
    model_writes(img);
    send_byte(8'h02, 1'b1);
    chk("img2_busy_after_first_byte", {31'd0, busy}, 32'd1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(32'h0000_0013);
    chk("img2_done_low_mid", {31'd0, done}, 32'd0);
    chk("img2_core_rst_n_low_mid", {31'd0, core_rst_n}, 32'd0);
    send_word(32'hDEAD_BEEF);
    chk("img2_done", {31'd0, done}, 32'd1);
    chk("img2_write_count", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() >= 2) begin
      chk("img2_lit_addr0", log_addr[0], 32'h0);
      chk("img2_lit_data0", log_data[0], 32'h0000_0013);
      chk("img2_lit_addr1", log_addr[1], 32'h4);
      chk("img2_lit_data1", log_data[1], 32'hDEAD_BEEF);
    end
    chk("img2_queue_drained", 32'(exp_addr_q.size()), 32'd0);

    // Empty image, then traffic after done
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("n0_done_before_last_byte", {31'd0, done}, 32'd0);
    send_byte(8'h00, 1'b1);
    chk("n0_done", {31'd0, done}, 32'd1);
    chk("n0_core_rst_n", {31'd0, core_rst_n}, 32'd1);
    chk("n0_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h31 + i), (i == 3) ? 1'b0 : 1'b1);
    chk("post_done_done", {31'd0, done}, 32'd1);
    chk("post_done_core_rst_n", {31'd0, core_rst_n}, 32'd1);
    chk("post_done_frame_err", {31'd0, frame_err}, 32'd0);
    chk("post_done_write_count", 32'(log_addr.size()), 32'd0);

    // Short low glitch is rejected
    do_reset();
    busy_seen = 0;
    rx = 1'b0;
    wait_cycles(CPB / 4);
    rx = 1'b1;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
    end
    chk("glitch_busy_cycles", 32'(busy_seen), 32'd0);
    chk("glitch_write_count", 32'(log_addr.size()), 32'd0);

    // Bad stop bit discarded, frame_err sticky
    do_reset();
    img.delete();
    img.push_back(32'h4433_2211);
    model_writes(img);
    send_word(32'd1);
    chk("ferr_before_bad_byte", {31'd0, frame_err}, 32'd0);
    send_byte(8'h55, 1'b0);
    chk("ferr_after_bad_byte", {31'd0, frame_err}, 32'd1);
    chk("ferr_busy_loading", {31'd0, busy}, 32'd1);
    send_word(32'h4433_2211);
    wait_done("ferr_done", 4 * CPB);
    chk("ferr_sticky", {31'd0, frame_err}, 32'd1);
    chk("ferr_write_count", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() >= 1) chk("ferr_lit_data", log_data[0], 32'h4433_2211);

    // Reset mid-word discards partial data
    do_reset();
    send_word(32'd1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    do_reset();
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_wea", {28'd0, wea}, 32'd0);
    chk("midrst_addra", addra, 32'd0);
    chk("midrst_dia", dia, 32'd0);
    #1;
    img.delete();
    img.push_back(32'hCAFE_F00D);
    model_writes(img);
    send_word(32'd1);
    send_word(32'hCAFE_F00D);
    wait_done("midrst_done_after_image", 4 * CPB);
    chk("midrst_write_count", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() >= 1) begin
      chk("midrst_lit_addr", log_addr[0], 32'h0);
      chk("midrst_lit_data", log_data[0], 32'hCAFE_F00D);
    end

    wait_cycles(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 868, giving the number of clk cycles per UART bit (100 MHz clock, 115200 baud).
REQ-002 The module SHALL have parameter ADDR_BASE, default 32'h0, giving the byte address of the first loaded word.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port rx, input, 1 bit: asynchronous UART serial data, 8N1 format, idle high.
REQ-006 The module SHALL have port wea, output, 4 bits: BRAM port-A byte write enables.
REQ-007 The module SHALL have port addra, output, 32 bits: BRAM port-A byte address.
REQ-008 The module SHALL have port dia, output, 32 bits: BRAM port-A write data.
REQ-009 The module SHALL have port core_rst_n, output, 1 bit: active-low reset for the pipeline core; low while loading.
REQ-010 The module SHALL have port busy, output, 1 bit: high while an image is being received.
REQ-011 The module SHALL have port done, output, 1 bit: high once the image is fully written.
REQ-012 The module SHALL have port frame_err, output, 1 bit: sticky flag for a bad stop bit.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-014 UART receive FSM SHALL have states RX_IDLE, RX_START, RX_DATA, RX_STOP.
- A low synchronized rx in RX_IDLE moves the FSM to RX_START.
REQ-015 In RX_START, after CLKS_PER_BIT/2 cycles, a high rx SHALL return the FSM to RX_IDLE (glitch rejection); a low rx SHALL move it to RX_DATA.
REQ-016 In RX_DATA, the FSM SHALL sample 8 data bits LSB-first, each CLKS_PER_BIT cycles after the previous sample.
REQ-017 In RX_STOP, the FSM SHALL sample the stop bit after CLKS_PER_BIT cycles and then return to RX_IDLE.
- stop=1: one-cycle byte_valid.
- stop=0: byte discarded, frame_err set to 1 until rst.
REQ-018 Bytes SHALL be packed little-endian: the first byte of each group of 4 goes to bits [7:0]; a 2-bit byte counter wraps 3->0.
REQ-019 Load FSM SHALL have states HDR, LOAD, DONE.
- HDR: the first completed word is latched as word count N (unsigned 32-bit).
- N=0: HDR goes to DONE.
- N>0: HDR goes to LOAD.
REQ-020 In LOAD, word k (k=0..N-1) SHALL be written with wea=4'hF for exactly one cycle, addra=ADDR_BASE+4*k (mod 2^32), dia=word.
- The write occurs in the cycle after the byte_valid of the word's 4th byte.
REQ-021 After the write of word N-1, the load FSM SHALL enter DONE.
REQ-022 Outside write cycles, wea SHALL be 4'h0; addra and dia hold their last values.
REQ-023 busy SHALL rise in the cycle after the first start bit is accepted in HDR, and fall when DONE is entered.
REQ-024 In DONE, done and core_rst_n SHALL be 1 starting the cycle after the final write (or after header latch when N=0); both hold until rst.
REQ-025 In DONE, all further rx activity SHALL be ignored: no writes, no frame_err update.
REQ-026 The word count and word index SHALL be 32-bit, with no overflow check.

Reset
REQ-027 While rst=1 at a clk edge, all outputs SHALL take these values: wea=0, addra=0, dia=0, core_rst_n=0, busy=0, done=0, frame_err=0.
REQ-028 At the same edge, both FSMs SHALL return to RX_IDLE/HDR and the byte counter and word index SHALL clear.
REQ-029 A reset mid-byte or mid-word SHALL discard the partial data; the next byte received is treated as header byte 0.

Verification
REQ-030 Send header 02 00 00 00, then 13 00 00 00, then EF BE AD DE -> two writes:
- 1st write: addr 0x0, data 0x00000013, wea=F.
- 2nd write: addr 0x4, data 0xDEADBEEF, wea=F.
- Next cycle: done=1, core_rst_n=1, busy=0.
REQ-031 Send header 00 00 00 00 -> no wea pulse; done=1 and core_rst_n=1 the cycle after the 4th header byte.
REQ-032 Send header N=1, then a byte with stop=0, then 4 valid bytes -> frame_err=1; the written word is the 4 valid bytes at addr ADDR_BASE.
REQ-033 Drive a rx low pulse of CLKS_PER_BIT/4 cycles -> no byte_valid, busy stays 0.
REQ-034 Assert rst for 1 cycle after 2 data bytes of word 0, then send full image N=1, 0xCAFEF00D -> a single write to addr 0x0 with 0xCAFEF00D.
REQ-035 After done, send 8 more bytes -> no wea pulse; done and core_rst_n stay 1.
